// File: rtl/jump_table_if.sv
// Lookup/write bus for the jump table: fetch-side request, loader write port,
// and the registered lookup result.
interface jump_table_if #(
  parameter int PTR_W  = 5,
  parameter int ADDR_W = 12
);
  logic              Req;
  logic [PTR_W-1:0]  Jptr;
  logic [ADDR_W-1:0] PC;
  logic              Wr_en;
  logic [PTR_W-1:0]  Wr_ptr;
  logic [ADDR_W-1:0] Wr_data;
  logic              Wr_rel;
  logic [ADDR_W-1:0] Jump;
  logic              Valid;
  logic              Err;
  logic              Busy;

  modport master (
    output Req, Jptr, PC, Wr_en, Wr_ptr, Wr_data, Wr_rel,
    input  Jump, Valid, Err, Busy
  );

  modport slave (
    input  Req, Jptr, PC, Wr_en, Wr_ptr, Wr_data, Wr_rel,
    output Jump, Valid, Err, Busy
  );
endinterface

// File: rtl/jump_table.sv
// Runtime-programmable branch-target table: absolute or PC-relative entries,
// cleared by an init sequencer after reset, one-cycle registered lookup.
module jump_table #(
  parameter int PTR_W  = 5,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 32
) (
  input  logic        Clk,
  input  logic        Reset_n,
  jump_table_if.slave bus
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_W  = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] tgt_q [DEPTH];
  logic              rel_q [DEPTH];

  logic              busy_q;
  logic [PTR_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] jump_q, jump_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              jptr_ok;
  logic              bypass;
  logic [ADDR_W-1:0] ent_data;
  logic              ent_rel;

  assign jptr_ok  = ({1'b0, bus.Jptr} < DEPTH_W);
  // A same-edge write to the looked-up entry wins over the stored value.
  assign bypass   = bus.Wr_en && (bus.Wr_ptr == bus.Jptr);
  assign ent_data = bypass ? bus.Wr_data : tgt_q[bus.Jptr];
  assign ent_rel  = bypass ? bus.Wr_rel  : rel_q[bus.Jptr];

  always_comb begin
    jump_d  = jump_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bus.Req && !busy_q) begin
      valid_d = 1'b1;
      if (!jptr_ok) begin
        err_d  = 1'b1;
        jump_d = '0;
      end else if (ent_rel) begin
        jump_d = bus.PC + ent_data;
      end else begin
        jump_d = ent_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      jump_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (busy_q) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST_PTR) begin
          busy_q <= 1'b0;
        end
      end
      jump_q  <= jump_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Each entry is either cleared by the sequencer or loaded by the write port;
  // out-of-range write pointers match no entry and are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk) begin
        if (Reset_n) begin
          if (busy_q) begin
            if (cnt_q == PTR_W'(gi)) begin
              tgt_q[gi] <= '0;
              rel_q[gi] <= 1'b0;
            end
          end else if (bus.Wr_en && (bus.Wr_ptr == PTR_W'(gi))) begin
            tgt_q[gi] <= bus.Wr_data;
            rel_q[gi] <= bus.Wr_rel;
          end
        end
      end
    end
  endgenerate

  assign bus.Jump  = jump_q;
  assign bus.Valid = valid_q;
  assign bus.Err   = err_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_jump_table.sv
// Drives a DEPTH=32 and a DEPTH=17 jump table with identical stimulus and
// checks both against a behavioural table model every cycle.
module tb_jump_table;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jump_table_if #(.PTR_W(5), .ADDR_W(12)) b32 ();
  jump_table_if #(.PTR_W(5), .ADDR_W(12)) b17 ();

  jump_table #(.PTR_W(5), .ADDR_W(12), .DEPTH(32)) dut32 (
    .Clk(clk), .Reset_n(rst_n), .bus(b32)
  );
  jump_table #(.PTR_W(5), .ADDR_W(12), .DEPTH(17)) dut17 (
    .Clk(clk), .Reset_n(rst_n), .bus(b17)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a plain table per instance plus a busy countdown.
  int          dep [2] = '{32, 17};
  logic [11:0] m_data [2][32];
  logic        m_rel  [2][32];
  int          m_left [2];
  logic [11:0] e_jump [2];
  logic        e_valid [2];
  logic        e_err [2];
  logic        e_busy [2];
  logic        started = 1'b0;

  function automatic logic [11:0] resolve(input int k);
    logic [11:0] d;
    logic        r;
    d = m_data[k][b32.Jptr];
    r = m_rel[k][b32.Jptr];
    if (b32.Wr_en && b32.Wr_ptr == b32.Jptr) begin
      d = b32.Wr_data;
      r = b32.Wr_rel;
    end
    return r ? 12'(b32.PC + d) : d;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        started    <= 1'b1;
        m_left[k]  <= dep[k];
        e_busy[k]  <= 1'b1;
        e_valid[k] <= 1'b0;
        e_err[k]   <= 1'b0;
        e_jump[k]  <= '0;
        for (int i = 0; i < 32; i++) begin
          m_data[k][i] <= '0;
          m_rel[k][i]  <= 1'b0;
        end
      end else if (m_left[k] > 0) begin
        m_left[k]  <= m_left[k] - 1;
        e_busy[k]  <= (m_left[k] > 1);
        e_valid[k] <= 1'b0;
        e_err[k]   <= 1'b0;
      end else begin
        e_busy[k]  <= 1'b0;
        e_valid[k] <= b32.Req;
        e_err[k]   <= 1'b0;
        if (b32.Req) begin
          if (int'(b32.Jptr) >= dep[k]) begin
            e_err[k]  <= 1'b1;
            e_jump[k] <= '0;
          end else begin
            e_jump[k] <= resolve(k);
          end
        end
        if (b32.Wr_en && int'(b32.Wr_ptr) < dep[k]) begin
          m_data[k][b32.Wr_ptr] <= b32.Wr_data;
          m_rel[k][b32.Wr_ptr]  <= b32.Wr_rel;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_jump32",  32'(b32.Jump),  32'(e_jump[0]));
      chk("cmp_valid32", 32'(b32.Valid), 32'(e_valid[0]));
      chk("cmp_err32",   32'(b32.Err),   32'(e_err[0]));
      chk("cmp_busy32",  32'(b32.Busy),  32'(e_busy[0]));
      chk("cmp_jump17",  32'(b17.Jump),  32'(e_jump[1]));
      chk("cmp_valid17", 32'(b17.Valid), 32'(e_valid[1]));
      chk("cmp_err17",   32'(b17.Err),   32'(e_err[1]));
      chk("cmp_busy17",  32'(b17.Busy),  32'(e_busy[1]));
    end
  end

  // Applies one cycle of inputs to both instances; returns at the next negedge
  // where the registered result of that cycle is visible.
  task automatic drive(input logic req, input logic [4:0] jp, input logic [11:0] pc,
                       input logic we, input logic [4:0] wp, input logic [11:0] wd,
                       input logic wr);
    b32.Req = req;  b17.Req = req;
    b32.Jptr = jp;  b17.Jptr = jp;
    b32.PC = pc;    b17.PC = pc;
    b32.Wr_en = we; b17.Wr_en = we;
    b32.Wr_ptr = wp; b17.Wr_ptr = wp;
    b32.Wr_data = wd; b17.Wr_data = wd;
    b32.Wr_rel = wr; b17.Wr_rel = wr;
    @(negedge clk);
    $display("cycle t=%0t req=%0b jptr=%0d pc=%03h we=%0b wptr=%0d wdata=%03h rel=%0b -> j32=%03h v=%0b e=%0b | j17=%03h v=%0b e=%0b",
             $time, req, jp, pc, we, wp, wd, wr, b32.Jump, b32.Valid, b32.Err,
             b17.Jump, b17.Valid, b17.Err);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 12'h000, 1'b0, 5'd0, 12'h000, 1'b0);
  endtask

  task automatic wr(input logic [4:0] wp, input logic [11:0] wd, input logic rel);
    drive(1'b0, 5'd0, 12'h000, 1'b1, wp, wd, rel);
  endtask

  task automatic rd(input logic [4:0] jp, input logic [11:0] pc);
    drive(1'b1, jp, pc, 1'b0, 5'd0, 12'h000, 1'b0);
  endtask

  // Starts at reset release; counts cycles with Busy high while issuing Req.
  task automatic count_busy(output int n32, output int n17);
    n32 = 0;
    n17 = 0;
    for (int i = 0; i < 40; i++) begin
      if (b32.Busy) n32++;
      if (b17.Busy) n17++;
      rd(5'd3, 12'h000);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask

  int c32, c17;

  initial begin
    do_reset();
    chk("reset_busy",  32'(b32.Busy),  32'd1);
    chk("reset_jump",  32'(b32.Jump),  32'd0);
    chk("reset_valid", 32'(b32.Valid), 32'd0);
    chk("reset_err",   32'(b32.Err),   32'd0);
    count_busy(c32, c17);
    chk("busy_len32", 32'(c32), 32'd32);
    chk("busy_len17", 32'(c17), 32'd17);

    rd(5'd7, 12'h000);
    chk("rd7_jump",  32'(b32.Jump),  32'd0);
    chk("rd7_valid", 32'(b32.Valid), 32'd1);
    chk("rd7_err",   32'(b32.Err),   32'd0);

    wr(5'd3, 12'd8, 1'b0);
    wr(5'd6, 12'd36, 1'b0);
    rd(5'd3, 12'h000);
    chk("abs3",   32'(b32.Jump),  32'd8);
    chk("abs3_v", 32'(b32.Valid), 32'd1);
    rd(5'd6, 12'h000);
    chk("abs6",   32'(b32.Jump),  32'd36);
    chk("abs6_v", 32'(b32.Valid), 32'd1);

    wr(5'd9, 12'hFF0, 1'b1);
    rd(5'd9, 12'h100);
    chk("rel_fwd",  32'(b32.Jump), 32'h0F0);
    rd(5'd9, 12'h008);
    chk("rel_wrap", 32'(b17.Jump), 32'hFF8);

    drive(1'b1, 5'd2, 12'h000, 1'b1, 5'd2, 12'd10, 1'b0);
    chk("bypass_same", 32'(b32.Jump), 32'd10);
    drive(1'b1, 5'd11, 12'h020, 1'b1, 5'd11, 12'h005, 1'b1);
    chk("bypass_rel", 32'(b17.Jump), 32'h025);
    drive(1'b1, 5'd6, 12'h000, 1'b1, 5'd3, 12'd100, 1'b0);
    chk("diff_ptr_old", 32'(b32.Jump), 32'd36);
    rd(5'd3, 12'h000);
    chk("diff_ptr_new", 32'(b32.Jump), 32'd100);
    idle();
    chk("hold_jump",  32'(b32.Jump),  32'd100);
    chk("hold_valid", 32'(b32.Valid), 32'd0);

    rd(5'd20, 12'h123);
    chk("oob17_jump",  32'(b17.Jump),  32'd0);
    chk("oob17_err",   32'(b17.Err),   32'd1);
    chk("oob17_valid", 32'(b17.Valid), 32'd1);
    chk("in32_err",    32'(b32.Err),   32'd0);
    wr(5'd20, 12'h555, 1'b0);
    rd(5'd20, 12'h000);
    chk("wr20_32",     32'(b32.Jump), 32'h555);
    chk("wr20_17_err", 32'(b17.Err),  32'd1);
    idle();
    chk("err_clear", 32'(b17.Err), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 12'h010);
    end

    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
    end
    do_reset();
    count_busy(c32, c17);
    chk("rebusy_len32", 32'(c32), 32'd32);
    chk("rebusy_len17", 32'(c17), 32'd17);
    rd(5'd3, 12'h000);
    chk("cleared3",   32'(b32.Jump),  32'd0);
    chk("cleared3_v", 32'(b32.Valid), 32'd1);
    rd(5'd20, 12'h000);
    chk("cleared20", 32'(b32.Jump), 32'd0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
